clk_div_cfg_ctrl: RTL and testbench
===================================

CLK_DIV_CFG_CTRL -- requirements
Module: clk_div_cfg_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 17, width of the divider counter being mirrored.
REQ-002 SHALL have parameter CFG_DATA_WIDTH, default 32, width of config input and output.
REQ-003 SHALL have parameter DEFAULT_CFG, default 50, divider terminal count applied out of reset.
REQ-004 SHALL have parameter MIN_CFG, default 2, smallest legal terminal count.
REQ-005 Port clk, input, 1, single clock, shared with the configurable divider.
REQ-006 Port resetn, input, 1, asynchronous active-low reset.
REQ-007 Port s_cfg_tdata, input, CFG_DATA_WIDTH, requested terminal count.
REQ-008 Port s_cfg_tvalid, input, 1, request valid.
REQ-009 Port s_cfg_tready, output, 1, request accept.
REQ-010 Port cfg_data, output, CFG_DATA_WIDTH, terminal count that drives the divider's cfg_data.
REQ-011 Port wrap_tick, output, 1, one-cycle pulse on every divider wrap (output-clock toggle).
REQ-012 Port pending, output, 1, staged value awaiting the next wrap.
REQ-013 Port clamped, output, 1, last accepted request was out of range and was clamped.

Function
REQ-014 SHALL keep a WIDTH-bit shadow counter cnt that mirrors the divider: nxt = cnt+1, wrapped to WIDTH bits.
REQ-015 SHALL define a wrap when nxt, zero-extended to CFG_DATA_WIDTH, equals cfg_data.
REQ-016 On a wrap: cnt <= 0 and wrap_tick <= 1 for one cycle; otherwise cnt <= nxt and wrap_tick <= 0.
REQ-017 SHALL run a two-state FSM: IDLE, PEND.
REQ-018 IDLE: s_cfg_tready = 1; on tvalid&tready, latch clamp(s_cfg_tdata) into a staging register; set clamped; go to PEND.
REQ-019 PEND: s_cfg_tready = 0; pending = 1; on a wrap cycle, cfg_data <= staging; go to IDLE.
REQ-020 cfg_data SHALL change only on the same edge on which cnt returns to 0, so the divider never sees a truncated or overrun half-period.
REQ-021 A request accepted in the same cycle as a wrap SHALL NOT apply at that wrap; it SHALL apply at the following wrap.
REQ-022 Clamp rule: value < MIN_CFG maps to MIN_CFG; value > 2^WIDTH-1 maps to 2^WIDTH-1; otherwise the value passes unchanged.
REQ-023 clamped SHALL be 1 iff the clamp rule altered the value; it updates only on acceptance and holds otherwise.
REQ-024 Half-period SHALL equal cfg_data cycles; output period SHALL equal 2*cfg_data cycles of clk.
REQ-025 A request equal to the current cfg_data SHALL still be accepted and take the full PEND path; there is no shortcut.
REQ-026 s_cfg_tready SHALL be registered-state derived only, with no combinational path from s_cfg_tvalid.

Reset
REQ-027 While resetn = 0, asynchronously set: cnt = 0, state = IDLE, cfg_data = DEFAULT_CFG, staging = DEFAULT_CFG, wrap_tick = 0, pending = 0, clamped = 0.
REQ-028 s_cfg_tready SHALL be 0 while resetn = 0 and SHALL become 1 on the first clk edge after deassertion.
REQ-029 Reset asserted in PEND SHALL discard the staged value; cfg_data returns to DEFAULT_CFG.
REQ-030 The divider SHALL share the same reset assertion so that cnt and the divider counter stay aligned; misalignment is out of scope.

Verification
REQ-031 Release reset, no requests -> wrap_tick every 50 cycles, first at cycle 50 after release, cfg_data = 50.
REQ-032 Request 10 at cnt = 20 -> tready drops next cycle; pending = 1 until cnt reaches 49; then cfg_data = 10 and subsequent wraps every 10 cycles.
REQ-033 Request 0, then request 200000 (WIDTH = 17) -> cfg_data = 2 with clamped = 1, then cfg_data = 131071 with clamped = 1; a later request of 7 clears clamped.
REQ-034 Request accepted exactly on a wrap cycle (cfg 50 -> 20) -> the next wrap is still 50 cycles later; the wraps after it are 20 apart.
REQ-035 tvalid held high with data 30, then 40 in PEND -> 40 is not accepted until 30 applies; tready = 0 throughout PEND.
REQ-036 resetn pulsed low mid-PEND (staged 5) -> cfg_data = 50, pending = 0, and the 5 is never applied.

Source files
------------

// File: rtl/clk_div_cfg_ctrl.sv
// clk_div_cfg_ctrl: safe runtime reconfiguration of a terminal-count clock divider.
// A shadow counter mirrors the divider. New terminal counts are accepted through a
// valid/ready handshake, clamped to the legal range, staged, and committed to cfg_data
// only on the edge where the divider wraps. This keeps every half-period whole.
//
// Ports:
//   clk, resetn    - shared divider clock, asynchronous active-low reset
//   s_cfg_tdata    - requested terminal count
//   s_cfg_tvalid   - request valid
//   s_cfg_tready   - request accept (registered; high only in IDLE)
//   cfg_data       - terminal count currently driving the divider
//   wrap_tick      - one-cycle pulse on each divider wrap
//   pending        - a staged value is waiting for the next wrap
//   clamped        - last accepted request was clamped into range
module clk_div_cfg_ctrl #(
  parameter int unsigned WIDTH          = 17,
  parameter int unsigned CFG_DATA_WIDTH = 32,
  parameter int unsigned DEFAULT_CFG    = 50,
  parameter int unsigned MIN_CFG        = 2
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [CFG_DATA_WIDTH-1:0] s_cfg_tdata,
  input  logic                      s_cfg_tvalid,
  output logic                      s_cfg_tready,
  output logic [CFG_DATA_WIDTH-1:0] cfg_data,
  output logic                      wrap_tick,
  output logic                      pending,
  output logic                      clamped
);

  localparam logic [CFG_DATA_WIDTH-1:0] CFG_DEFAULT = CFG_DATA_WIDTH'(DEFAULT_CFG);
  localparam logic [CFG_DATA_WIDTH-1:0] CFG_MIN     = CFG_DATA_WIDTH'(MIN_CFG);
  localparam logic [CFG_DATA_WIDTH-1:0] CFG_MAX     = CFG_DATA_WIDTH'((64'd1 << WIDTH) - 64'd1);

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t                      state, state_d;
  logic [WIDTH-1:0]            cnt, cnt_d, nxt;
  logic [CFG_DATA_WIDTH-1:0]   staging, staging_d, cfg_d, clamp_val;
  logic                        wrap, clamp_hit;
  logic                        tick_d, pending_d, clamped_d, tready_d;

  // Shadow divider: a wrap is the cycle whose successor count equals the terminal count.
  always_comb begin
    nxt  = cnt + WIDTH'(1);
    wrap = (CFG_DATA_WIDTH'(nxt) == cfg_data);
  end

  // Clamp a request into [MIN_CFG, 2^WIDTH-1].
  always_comb begin
    clamp_val = s_cfg_tdata;
    clamp_hit = 1'b0;
    if (s_cfg_tdata < CFG_MIN) begin
      clamp_val = CFG_MIN;
      clamp_hit = 1'b1;
    end else if (s_cfg_tdata > CFG_MAX) begin
      clamp_val = CFG_MAX;
      clamp_hit = 1'b1;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state;
    staging_d = staging;
    cfg_d     = cfg_data;
    clamped_d = clamped;
    cnt_d     = wrap ? '0 : nxt;
    tick_d    = wrap;
    unique case (state)
      IDLE: begin
        // An acceptance coinciding with a wrap only stages; it commits at the next wrap.
        if (s_cfg_tvalid && s_cfg_tready) begin
          staging_d = clamp_val;
          clamped_d = clamp_hit;
          state_d   = PEND;
        end
      end
      PEND: begin
        if (wrap) begin
          cfg_d   = staging;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Handshake flags follow the next state so they never depend combinationally on tvalid.
    tready_d  = (state_d == IDLE);
    pending_d = (state_d == PEND);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      cnt          <= '0;
      cfg_data     <= CFG_DEFAULT;
      staging      <= CFG_DEFAULT;
      wrap_tick    <= 1'b0;
      pending      <= 1'b0;
      clamped      <= 1'b0;
      s_cfg_tready <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      cfg_data     <= cfg_d;
      staging      <= staging_d;
      wrap_tick    <= tick_d;
      pending      <= pending_d;
      clamped      <= clamped_d;
      s_cfg_tready <= tready_d;
    end
  end

endmodule

// File: tb/tb_clk_div_cfg_ctrl.sv
// Scoreboard bench for clk_div_cfg_ctrl: each phase pushes the hand-computed wrap
// cycles (cycle count since reset release, cfg_data, clamped) into a queue; a monitor
// pops and compares on every wrap_tick. Point checks cover handshake and reset.
`timescale 1ns/1ps
module tb_clk_div_cfg_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] s_cfg_tdata = '0;
  logic        s_cfg_tvalid = 1'b0;
  logic        s_cfg_tready;
  logic [31:0] cfg_data;
  logic        wrap_tick;
  logic        pending;
  logic        clamped;

  clk_div_cfg_ctrl #(
    .WIDTH(17), .CFG_DATA_WIDTH(32), .DEFAULT_CFG(50), .MIN_CFG(2)
  ) dut (
    .clk(clk), .resetn(resetn),
    .s_cfg_tdata(s_cfg_tdata), .s_cfg_tvalid(s_cfg_tvalid), .s_cfg_tready(s_cfg_tready),
    .cfg_data(cfg_data), .wrap_tick(wrap_tick), .pending(pending), .clamped(clamped)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] cfg;
    logic        clamped;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  // Posedges since the last reset release.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int c, input logic [31:0] v, input logic cl);
    exp_t e;
    e.cyc = c; e.cfg = v; e.clamped = cl;
    q.push_back(e);
  endtask

  // Monitor: every wrap_tick consumes one expected entry.
  always @(negedge clk) begin
    if (resetn && wrap_tick) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_wrap @cyc %0d: got wrap_tick expected none", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("wrap_cycle", 64'(cyc), 64'(e.cyc));
        check("wrap_cfg", 64'(cfg_data), 64'(e.cfg));
        check("wrap_clamped", 64'(clamped), 64'(e.clamped));
      end
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic drain();
    check("sb_drain", 64'(q.size()), 64'd0);
    q.delete();
  endtask

  // Assert reset asynchronously, check reset values, release on a negedge (cyc = 0).
  task automatic do_reset();
    @(negedge clk);
    #1;
    resetn = 1'b0;
    s_cfg_tvalid = 1'b0;
    s_cfg_tdata  = '0;
    #1;
    check("rst_tready", 64'(s_cfg_tready), 64'd0);
    check("rst_cfg", 64'(cfg_data), 64'd50);
    check("rst_pending", 64'(pending), 64'd0);
    check("rst_clamped", 64'(clamped), 64'd0);
    check("rst_tick", 64'(wrap_tick), 64'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Phase A: default period, then request 10 at cnt = 20.
    do_reset();
    push(50, 50, 0); push(100, 50, 0); push(150, 10, 0); push(160, 10, 0); push(170, 10, 0);
    wait_cyc(1);
    check("tready_after_rst", 64'(s_cfg_tready), 64'd1);
    wait_cyc(120);
    s_cfg_tdata = 32'd10; s_cfg_tvalid = 1'b1;
    wait_cyc(121);
    s_cfg_tvalid = 1'b0;
    check("a_tready_drop", 64'(s_cfg_tready), 64'd0);
    check("a_pending", 64'(pending), 64'd1);
    wait_cyc(149);
    check("a_pending_149", 64'(pending), 64'd1);
    check("a_cfg_149", 64'(cfg_data), 64'd50);
    wait_cyc(150);
    check("a_pending_150", 64'(pending), 64'd0);
    check("a_tready_150", 64'(s_cfg_tready), 64'd1);
    wait_cyc(175);
    drain();

    // Phase B: request 20 accepted on the wrap edge; then a same-value request.
    do_reset();
    push(50, 50, 0); push(100, 20, 0); push(120, 20, 0); push(140, 20, 0);
    wait_cyc(49);
    s_cfg_tdata = 32'd20; s_cfg_tvalid = 1'b1;
    wait_cyc(50);
    s_cfg_tvalid = 1'b0;
    check("b_cfg_kept", 64'(cfg_data), 64'd50);
    check("b_pending", 64'(pending), 64'd1);
    wait_cyc(141);
    s_cfg_tdata = 32'd20; s_cfg_tvalid = 1'b1;
    wait_cyc(142);
    s_cfg_tvalid = 1'b0;
    check("b_same_pending", 64'(pending), 64'd1);
    check("b_same_tready", 64'(s_cfg_tready), 64'd0);
    wait_cyc(145);
    drain();

    // Phase C: clamping low and high, then an in-range request clears clamped.
    do_reset();
    push(50, 2, 1); push(52, 2, 1); push(54, 2, 1); push(56, 2, 1); push(58, 131071, 1);
    wait_cyc(5);
    s_cfg_tdata = 32'd0; s_cfg_tvalid = 1'b1;
    wait_cyc(6);
    s_cfg_tvalid = 1'b0;
    check("c_clamped_low", 64'(clamped), 64'd1);
    check("c_cfg_not_yet", 64'(cfg_data), 64'd50);
    wait_cyc(55);
    s_cfg_tdata = 32'd200000; s_cfg_tvalid = 1'b1;
    wait_cyc(56);
    s_cfg_tvalid = 1'b0;
    check("c_cfg_56", 64'(cfg_data), 64'd2);
    wait_cyc(60);
    s_cfg_tdata = 32'd7; s_cfg_tvalid = 1'b1;
    wait_cyc(61);
    s_cfg_tvalid = 1'b0;
    check("c_clamped_clear", 64'(clamped), 64'd0);
    check("c_cfg_hold", 64'(cfg_data), 64'd131071);
    check("c_pending", 64'(pending), 64'd1);
    wait_cyc(65);
    drain();

    // Phase D: tvalid held through PEND; second value waits for the first to apply.
    do_reset();
    push(50, 30, 0); push(80, 40, 0); push(120, 40, 0);
    wait_cyc(10);
    s_cfg_tdata = 32'd30; s_cfg_tvalid = 1'b1;
    wait_cyc(11);
    s_cfg_tdata = 32'd40;
    begin
      int bad = 0;
      for (int c = 11; c < 50; c++) begin
        wait_cyc(c);
        if (s_cfg_tready !== 1'b0) bad++;
      end
      check("d_tready_low_in_pend", 64'(bad), 64'd0);
    end
    wait_cyc(50);
    check("d_tready_50", 64'(s_cfg_tready), 64'd1);
    wait_cyc(51);
    s_cfg_tvalid = 1'b0;
    check("d_tready_51", 64'(s_cfg_tready), 64'd0);
    check("d_pending_51", 64'(pending), 64'd1);
    wait_cyc(125);
    drain();

    // Phase E: reset mid-PEND discards staged 5.
    do_reset();
    wait_cyc(10);
    s_cfg_tdata = 32'd5; s_cfg_tvalid = 1'b1;
    wait_cyc(11);
    s_cfg_tvalid = 1'b0;
    wait_cyc(20);
    check("e_pending_pre", 64'(pending), 64'd1);
    drain();
    do_reset();
    push(50, 50, 0); push(100, 50, 0);
    wait_cyc(105);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
